grf_mp_sb: RTL and testbench
============================

// Module: grf_mp_sb
// PURPOSE
// - Parametrised general register file for the pipelined CPU: NR read ports, NW write ports, DW-bit registers, 2**AW entries.
// - Same-cycle write-to-read bypass. Register 0 is hardwired to zero.
// - Adds a per-register busy scoreboard. Issue marks a destination pending; writeback clears it. The hazard unit stalls on busy sources.
// - Sits between the decode stage (reads and issue) and the writeback stage(s) (writes).
// PARAMETERS
// - DW      32  register data width
// - AW      5   address width; depth = 2**AW
// - NR      2   number of read ports (>=1)
// - NW      2   number of write ports (>=1); higher index = higher priority
// - BYPASS  1   1: a read returns same-cycle write data; 0: a read returns stored value only
// PORTS
// - clk      in   1      clock, all state updates on posedge
// - reset    in   1      synchronous, active-high; clears all registers and all busy bits
// - ra       in   NR*AW  read addresses, port i at [i*AW +: AW]
// - rd       out  NR*DW  read data, port i at [i*DW +: DW]
// - rbusy    out  NR     port i source is pending (scoreboard bit, after this cycle's clears)
// - we       in   NW     write enables
// - wa       in   NW*AW  write addresses
// - wd       in   NW*DW  write data
// - iss_en   in   1      mark iss_addr busy (instruction with destination issued)
// - iss_addr in   AW     destination to mark busy
// - busy_vec out  2**AW  full scoreboard state (registered), debug/hazard use
// BEHAVIOUR
// - Reset: every register = 0, busy_vec = 0. A reset asserted mid-operation overrides any same-cycle write or issue.
//   While reset is high, rd shows the stored values with no bypass; after reset, rd = 0 and rbusy = 0.
// - Write: on posedge, for each port j with we[j] and wa[j]!=0, reg[wa[j]] <= wd[j].
//   Same address on several enabled ports: the highest j wins. Writes to address 0 are discarded.
// - Read (combinational, 0-cycle latency):
//   - ra[i]==0 -> rd = 0.
//   - Else if BYPASS and some enabled write hits ra[i] -> rd = wd of the highest-index hitting port.
//   - Else -> rd = reg[ra[i]].
//   - The bypass is gated off while reset is high.
// - Scoreboard, per register r, on posedge:
//   - set = iss_en && iss_addr==r && r!=0.
//   - clr = some enabled write has wa==r.
//   - busy[r] <= set ? 1 : (clr ? 0 : busy[r]).
//   - If set and clr happen together, set wins: the new producer supersedes the retiring one.
//   - busy[0] is always 0. Issuing to an already-busy register leaves it busy. No counting; one outstanding producer per register is guaranteed by the pipeline.
// - rbusy[i] = busy[ra[i]] && !(BYPASS && a same-cycle write hits ra[i]). A value being written this cycle is not a hazard when bypassed. With BYPASS=0, rbusy[i] = busy[ra[i]].
// - Width rules: all data is unsigned DW bits; no extension or truncation inside the block.
// - No X on outputs after the first reset. An initial block also zeroes the state for simulation.
// STRUCTURE
// - Shared header grf_defs: default DW/AW/NR/NW values, ZERO_REG = 0.
// - Sub-module grf_scoreboard(AW, NW): busy_vec register, set/clr logic, exposes busy_vec.
// - Top level: storage array, priority write loop, per-port read/bypass mux, rbusy masking.
// TESTING
// - Reset, then read all 32 addresses on both ports -> rd=0, rbusy=0, busy_vec=0.
// - we=2'b11, wa0=wa1=5, wd0=0x1111_1111, wd1=0x2222_2222, ra0=5:
//   - same cycle, rd0=0x2222_2222 (BYPASS=1);
//   - next cycle, reg5 reads 0x2222_2222.
// - Write 0xDEAD_BEEF to address 0 -> ra=0 reads 0 in the same cycle and afterwards; busy_vec[0] stays 0.
// - iss_en, iss_addr=7 -> next cycle busy_vec[7]=1 and rbusy=1 for ra=7.
//   - Later a write to 7 -> rbusy=0 in the write cycle, busy_vec[7]=0 next cycle.
// - Same cycle: iss_en to 9 and we to 9 while busy[9]=1 -> busy_vec[9] stays 1. Write-only to 9 -> 0.
// - Write 0x55 to reg 3 and iss to 4, then reset together with we to 3 = 0x77 -> reg3=0 and busy_vec=0 next cycle.
//   - Repeat with BYPASS=0: same-cycle read of a written address returns the old value.

Source files
------------

// File: rtl/grf_mp_sb_pkg.sv
// Shared definitions for the multi-port general register file and its scoreboard.
// Default geometry and the hardwired zero register index.
package grf_mp_sb_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;
  localparam int DEF_NR   = 2;
  localparam int DEF_NW   = 2;
  localparam int ZERO_REG = 0;

endpackage : grf_mp_sb_pkg

// File: rtl/grf_mp_sb_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback clears it.
// A same-cycle issue and writeback to one register leaves it busy (new producer wins).
module grf_scoreboard
  import grf_mp_sb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int NW = DEF_NW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     wa,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] set_s;
  logic [DEPTH-1:0] clr_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [DEPTH-1:0] busy_r;

  // Decode issue and writeback into per-register set/clear masks
  always_comb begin
    set_s      = '0;
    clr_s      = '0;
    busy_nxt_s = '0;
    if (iss_en) begin
      set_s[iss_addr] = 1'b1;
    end else begin
      set_s = '0;
    end
    for (int j = 0; j < NW; j++) begin
      if (we[j]) begin
        clr_s[wa[j*AW +: AW]] = 1'b1;
      end else begin
        clr_s = clr_s;
      end
    end
    busy_nxt_s           = set_s | (busy_r & ~clr_s);
    busy_nxt_s[ZERO_REG] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_vec = busy_r;

endmodule : grf_scoreboard

// File: rtl/grf_mp_sb.sv
// General register file: NR combinational read ports with optional write bypass,
// NW prioritised write ports (highest index wins), register 0 hardwired to zero.
module grf_mp_sb
  import grf_mp_sb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int NR     = DEF_NR,
  parameter int NW     = DEF_NW,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NR*AW-1:0]     ra,
  output logic [NR*DW-1:0]     rd,
  output logic [NR-1:0]        rbusy,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     wa,
  input  logic [NW*DW-1:0]     wd,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  logic [DW-1:0] mem_r [DEPTH];
  logic          byp_on_s;

  // Bypass is suppressed during reset so reads show stored contents only
  assign byp_on_s = (BYPASS != 0) && !reset;

  // Storage update; later ports overwrite earlier ones on an address clash
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (wa[j*AW +: AW] != ZADDR)) begin
          mem_r[wa[j*AW +: AW]] <= wd[j*DW +: DW];
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] addr_s;
    logic          hit_s;
    logic [DW-1:0] bdat_s;
    logic [DW-1:0] rdat_s;
    logic          rb_s;

    assign addr_s = ra[i*AW +: AW];

    // Read mux: zero register, then highest-index bypass hit, then storage
    always_comb begin
      hit_s  = 1'b0;
      bdat_s = '0;
      rdat_s = '0;
      rb_s   = 1'b0;
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (wa[j*AW +: AW] == addr_s)) begin
          hit_s  = 1'b1;
          bdat_s = wd[j*DW +: DW];
        end else begin
          hit_s  = hit_s;
        end
      end
      if (addr_s == ZADDR) begin
        rdat_s = '0;
      end else if (byp_on_s && hit_s) begin
        rdat_s = bdat_s;
      end else begin
        rdat_s = mem_r[addr_s];
      end
      rb_s = busy_vec[addr_s] && !(byp_on_s && hit_s);
    end

    assign rd[i*DW +: DW] = rdat_s;
    assign rbusy[i]       = rb_s;
  end

  grf_scoreboard #(
    .AW (AW),
    .NW (NW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we       (we),
    .wa       (wa),
    .busy_vec (busy_vec)
  );

endmodule : grf_mp_sb

// File: tb/tb_grf_mp_sb.sv
// Directed vector bench for grf_mp_sb: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_grf_mp_sb;

  logic        clk;
  logic        reset;
  logic [9:0]  ra;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_b;
  logic [1:0]  rbusy_b;
  logic [31:0] busy_b;
  logic [63:0] rd_n;
  logic [1:0]  rbusy_n;
  logic [31:0] busy_n;

  int total;
  int bad;

  grf_mp_sb #(.DW(32), .AW(5), .NR(2), .NW(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_b)
  );

  grf_mp_sb #(.DW(32), .AW(5), .NR(2), .NW(2), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        iss;
    logic [4:0]  ia;
    logic [31:0] e_rd0, e_rd1, e_nrd0;
    logic [1:0]  e_rb, e_nrb;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset    = v.rst;
    we       = v.we;
    wa       = {v.wa1, v.wa0};
    wd       = {v.wd1, v.wd0};
    ra       = {v.ra1, v.ra0};
    iss_en   = v.iss;
    iss_addr = v.ia;
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] w,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic is, input logic [4:0] ia,
                              input logic [31:0] erd0, input logic [31:0] erd1,
                              input logic [31:0] enrd0, input logic [1:0] erb,
                              input logic [1:0] enrb, input logic [31:0] ebusy);
    vec_t v;
    v.rst = rst; v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.ra0 = r0; v.ra1 = r1; v.iss = is; v.ia = ia;
    v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_nrd0 = enrd0;
    v.e_rb = erb; v.e_nrb = enrb; v.e_busy = ebusy;
    return v;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    //            rst  we     wa0    wd0            wa1    wd1            ra0    ra1    iss   ia     rd0            rd1            nrd0           rb     nrb    busy
    vecs[0]  = mk(1'b0, 2'b11, 5'd5,  32'h1111_1111, 5'd5,  32'h2222_2222, 5'd5,  5'd5,  1'b0, 5'd0,  32'h2222_2222, 32'h2222_2222, 32'h0,         2'b00, 2'b00, 32'h0);
    vecs[1]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd0,  1'b0, 5'd0,  32'h2222_2222, 32'h0,         32'h2222_2222, 2'b00, 2'b00, 32'h0);
    vecs[2]  = mk(1'b0, 2'b01, 5'd0,  32'hDEAD_BEEF, 5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0,         2'b00, 2'b00, 32'h0);
    vecs[3]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd5,  1'b0, 5'd0,  32'h0,         32'h2222_2222, 32'h0,         2'b00, 2'b00, 32'h0);
    vecs[4]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd7,  1'b1, 5'd7,  32'h0,         32'h0,         32'h0,         2'b00, 2'b00, 32'h0);
    vecs[5]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd5,  1'b0, 5'd0,  32'h0,         32'h2222_2222, 32'h0,         2'b01, 2'b01, 32'h0000_0080);
    vecs[6]  = mk(1'b0, 2'b10, 5'd0,  32'h0,         5'd7,  32'h0000_0777, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0000_0777, 32'h0000_0777, 32'h0,         2'b00, 2'b11, 32'h0000_0080);
    vecs[7]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd7,  1'b0, 5'd0,  32'h0000_0777, 32'h0000_0777, 32'h0000_0777, 2'b00, 2'b00, 32'h0);
    vecs[8]  = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd0,  1'b1, 5'd9,  32'h0,         32'h0,         32'h0,         2'b00, 2'b00, 32'h0);
    vecs[9]  = mk(1'b0, 2'b01, 5'd9,  32'h0000_0099, 5'd0,  32'h0,         5'd9,  5'd9,  1'b1, 5'd9,  32'h0000_0099, 32'h0000_0099, 32'h0,         2'b00, 2'b11, 32'h0000_0200);
    vecs[10] = mk(1'b0, 2'b01, 5'd9,  32'h0000_009A, 5'd0,  32'h0,         5'd9,  5'd9,  1'b0, 5'd0,  32'h0000_009A, 32'h0000_009A, 32'h0000_0099, 2'b00, 2'b11, 32'h0000_0200);
    vecs[11] = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd9,  1'b0, 5'd0,  32'h0000_009A, 32'h0000_009A, 32'h0000_009A, 2'b00, 2'b00, 32'h0);
    vecs[12] = mk(1'b0, 2'b01, 5'd3,  32'h0000_0055, 5'd0,  32'h0,         5'd3,  5'd4,  1'b1, 5'd4,  32'h0000_0055, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0);
    vecs[13] = mk(1'b1, 2'b01, 5'd3,  32'h0000_0077, 5'd0,  32'h0,         5'd3,  5'd4,  1'b1, 5'd4,  32'h0000_0055, 32'h0,         32'h0000_0055, 2'b10, 2'b10, 32'h0000_0010);
    vecs[14] = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd5,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0,         2'b00, 2'b00, 32'h0);
    vecs[15] = mk(1'b0, 2'b11, 5'd10, 32'h0000_00A0, 5'd11, 32'h0000_00B1, 5'd10, 5'd11, 1'b0, 5'd0,  32'h0000_00A0, 32'h0000_00B1, 32'h0,         2'b00, 2'b00, 32'h0);
    vecs[16] = mk(1'b0, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd10, 5'd11, 1'b0, 5'd0,  32'h0000_00A0, 32'h0000_00B1, 32'h0000_00A0, 2'b00, 2'b00, 32'h0);

    // Reset sequence, then sweep every address on both ports
    reset = 1'b1; we = 2'b00; wa = 10'd0; wd = 64'd0; ra = 10'd0;
    iss_en = 1'b0; iss_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #3;
      chk("reset_rd", rd_b[31:0] | rd_b[63:32] | rd_n[31:0] | rd_n[63:32], 32'h0);
      chk("reset_rbusy", {30'd0, rbusy_b | rbusy_n}, 32'h0);
      chk("reset_busy_vec", busy_b | busy_n, 32'h0);
      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 17; k++) begin
      apply(vecs[k]);
      #3;
      chk($sformatf("v%0d_rd0", k), rd_b[31:0], vecs[k].e_rd0);
      chk($sformatf("v%0d_rd1", k), rd_b[63:32], vecs[k].e_rd1);
      chk($sformatf("v%0d_nobyp_rd0", k), rd_n[31:0], vecs[k].e_nrd0);
      chk($sformatf("v%0d_rbusy", k), {30'd0, rbusy_b}, {30'd0, vecs[k].e_rb});
      chk($sformatf("v%0d_nobyp_rbusy", k), {30'd0, rbusy_n}, {30'd0, vecs[k].e_nrb});
      chk($sformatf("v%0d_busy_vec", k), busy_b, vecs[k].e_busy);
      chk($sformatf("v%0d_nobyp_busy_vec", k), busy_n, vecs[k].e_busy);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_grf_mp_sb
